// File: rtl/alu_issue.sv
// Issue stage for a MIPS integer ALU: decodes one instruction, drives an external ALU for one cycle,
// then holds the masked result until the consumer accepts it.
module alu_issue (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_aluc,
  input  logic [31:0] alu_r,
  input  logic        alu_zero,
  input  logic        alu_carry,
  input  logic        alu_negative,
  input  logic        alu_overflow,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_r,
  output logic [3:0]  out_flags,
  output logic        out_illegal
);

  localparam logic [3:0] OpAddu = 4'b0000;
  localparam logic [3:0] OpSubu = 4'b0001;
  localparam logic [3:0] OpAdd  = 4'b0010;
  localparam logic [3:0] OpSub  = 4'b0011;
  localparam logic [3:0] OpAnd  = 4'b0100;
  localparam logic [3:0] OpOr   = 4'b0101;
  localparam logic [3:0] OpXor  = 4'b0110;
  localparam logic [3:0] OpNor  = 4'b0111;
  localparam logic [3:0] OpLui  = 4'b1000;
  localparam logic [3:0] OpSltu = 4'b1010;
  localparam logic [3:0] OpSlt  = 4'b1011;
  localparam logic [3:0] OpSra  = 4'b1100;
  localparam logic [3:0] OpSrl  = 4'b1101;
  localparam logic [3:0] OpSll  = 4'b1110;

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [3:0]  alu_aluc_q, alu_aluc_d;
  logic [31:0] out_r_q, out_r_d;
  logic [3:0]  out_flags_q, out_flags_d;
  logic        out_illegal_q, out_illegal_d;

  logic        dec_legal;
  logic [3:0]  dec_aluc;
  logic [31:0] dec_a, dec_b;
  logic [31:0] imm_sext, imm_zext, shamt_ext;
  logic        carry_en, ovf_en;

  assign imm_sext  = {{16{instr[15]}}, instr[15:0]};
  assign imm_zext  = {16'b0, instr[15:0]};
  assign shamt_ext = {27'b0, instr[10:6]};

  always_comb begin
    dec_legal = 1'b1;
    dec_aluc  = OpAddu;
    dec_a     = rs_val;
    dec_b     = rt_val;
    if (instr[31:26] == 6'b000000) begin
      case (instr[5:0])
        6'b100000: dec_aluc = OpAdd;
        6'b100001: dec_aluc = OpAddu;
        6'b100010: dec_aluc = OpSub;
        6'b100011: dec_aluc = OpSubu;
        6'b100100: dec_aluc = OpAnd;
        6'b100101: dec_aluc = OpOr;
        6'b100110: dec_aluc = OpXor;
        6'b100111: dec_aluc = OpNor;
        6'b101010: dec_aluc = OpSlt;
        6'b101011: dec_aluc = OpSltu;
        6'b000000: begin dec_aluc = OpSll; dec_a = shamt_ext; end
        6'b000010: begin dec_aluc = OpSrl; dec_a = shamt_ext; end
        6'b000011: begin dec_aluc = OpSra; dec_a = shamt_ext; end
        6'b000100: dec_aluc = OpSll;
        6'b000110: dec_aluc = OpSrl;
        6'b000111: dec_aluc = OpSra;
        default:   dec_legal = 1'b0;
      endcase
    end else begin
      case (instr[31:26])
        6'b001000: begin dec_aluc = OpAdd;  dec_b = imm_sext; end
        6'b001001: begin dec_aluc = OpAddu; dec_b = imm_sext; end
        6'b001010: begin dec_aluc = OpSlt;  dec_b = imm_sext; end
        6'b001011: begin dec_aluc = OpSltu; dec_b = imm_sext; end
        6'b001100: begin dec_aluc = OpAnd;  dec_b = imm_zext; end
        6'b001101: begin dec_aluc = OpOr;   dec_b = imm_zext; end
        6'b001110: begin dec_aluc = OpXor;  dec_b = imm_zext; end
        6'b001111: begin dec_aluc = OpLui;  dec_b = imm_zext; end
        default:   dec_legal = 1'b0;
      endcase
    end
  end

  // Flag masks follow the op held in the ALU register during EXEC.
  always_comb begin
    carry_en = 1'b0;
    ovf_en   = 1'b0;
    case (alu_aluc_q)
      OpAddu, OpSubu, OpSltu, OpSra, OpSrl, OpSll: carry_en = 1'b1;
      OpAdd, OpSub:                                ovf_en   = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_aluc_d    = alu_aluc_q;
    out_r_d       = out_r_q;
    out_flags_d   = out_flags_q;
    out_illegal_d = out_illegal_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (dec_legal) begin
            alu_a_d    = dec_a;
            alu_b_d    = dec_b;
            alu_aluc_d = dec_aluc;
            state_d    = StExec;
          end else begin
            out_r_d       = '0;
            out_flags_d   = '0;
            out_illegal_d = 1'b1;
            state_d       = StDone;
          end
        end
      end
      StExec: begin
        out_r_d       = alu_r;
        out_flags_d   = {alu_zero, alu_carry & carry_en, alu_negative, alu_overflow & ovf_en};
        out_illegal_d = 1'b0;
        state_d       = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_aluc_q    <= '0;
      out_r_q       <= '0;
      out_flags_q   <= '0;
      out_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_aluc_q    <= alu_aluc_d;
      out_r_q       <= out_r_d;
      out_flags_q   <= out_flags_d;
      out_illegal_q <= out_illegal_d;
    end
  end

  assign in_ready    = (state_q == StIdle);
  assign out_valid   = (state_q == StDone);
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_aluc    = alu_aluc_q;
  assign out_r       = out_r_q;
  assign out_flags   = out_flags_q;
  assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a behavioural ALU attached to the operand/result ports.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = '0, rs_val = '0, rt_val = '0;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_aluc;
  logic [31:0] alu_r;
  logic        alu_zero, alu_carry, alu_negative, alu_overflow;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_r;
  logic [3:0]  out_flags;
  logic        out_illegal;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_issue dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .rs_val(rs_val), .rt_val(rt_val), .alu_a(alu_a), .alu_b(alu_b), .alu_aluc(alu_aluc),
    .alu_r(alu_r), .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_negative(alu_negative),
    .alu_overflow(alu_overflow), .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r),
    .out_flags(out_flags), .out_illegal(out_illegal)
  );

  // Behavioural ALU: carry/overflow are produced raw so the DUT's masking is exercised.
  logic [32:0] m_sum;
  logic [31:0] m_tmp;
  logic [4:0]  m_sh;
  always_comb begin
    m_sum        = '0;
    m_tmp        = '0;
    m_sh         = alu_a[4:0];
    alu_r        = '0;
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    case (alu_aluc)
      4'b0000, 4'b0010: begin
        m_sum        = {1'b0, alu_a} + {1'b0, alu_b};
        alu_r        = m_sum[31:0];
        alu_carry    = m_sum[32];
        alu_overflow = (alu_a[31] == alu_b[31]) && (m_sum[31] != alu_a[31]);
      end
      4'b0001, 4'b0011: begin
        alu_r        = alu_a - alu_b;
        alu_carry    = alu_a < alu_b;
        alu_overflow = (alu_a[31] != alu_b[31]) && (alu_r[31] != alu_a[31]);
      end
      4'b0100: alu_r = alu_a & alu_b;
      4'b0101: alu_r = alu_a | alu_b;
      4'b0110: alu_r = alu_a ^ alu_b;
      4'b0111: alu_r = ~(alu_a | alu_b);
      4'b1000: alu_r = {alu_b[15:0], 16'b0};
      4'b1010: begin alu_r = {31'b0, alu_a < alu_b}; alu_carry = alu_a < alu_b; end
      4'b1011: alu_r = {31'b0, $signed(alu_a) < $signed(alu_b)};
      4'b1100, 4'b1101: begin
        alu_r     = (alu_aluc == 4'b1100) ? 32'($signed(alu_b) >>> m_sh) : alu_b >> m_sh;
        m_tmp     = alu_b >> (m_sh - 5'd1);
        alu_carry = (m_sh != 5'd0) && m_tmp[0];
      end
      4'b1110: begin
        alu_r     = alu_b << m_sh;
        m_tmp     = alu_b >> (6'd32 - {1'b0, m_sh});
        alu_carry = (m_sh != 5'd0) && m_tmp[0];
      end
      default: ;
    endcase
    alu_zero     = (alu_r == 32'b0);
    alu_negative = alu_r[31];
  end

  function automatic logic [31:0] rtype(input logic [4:0] sh, input logic [5:0] fn);
    return {21'b0, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [15:0] imm);
    return {op, 10'b0, imm};
  endfunction

  // Present one request for exactly one edge, then scramble the request inputs.
  task automatic send(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt);
    instr = i; rs_val = rs; rt_val = rt; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; instr = 32'hFFFF_FFFF; rs_val = 32'hA5A5_A5A5; rt_val = 32'h5A5A_5A5A;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({in_ready, out_valid, out_illegal, out_r, out_flags, alu_a, alu_b, alu_aluc} !==
        {1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0}) begin
      n_fail++;
      $display("FAIL reset: got rdy=%b v=%b ill=%b r=%h f=%b a=%h b=%h op=%b want idle/zeros",
               in_ready, out_valid, out_illegal, out_r, out_flags, alu_a, alu_b, alu_aluc);
    end
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [31:0] i, rs, rt, a, b;
    logic [3:0]  op;
    logic [31:0] r;
    logic [3:0]  f;
  } vec_t;

  task automatic test_alu_ops;
    vec_t v[16];
    v[0]  = '{rtype(0, 6'h20), 32'h7FFFFFFF, 32'h1, 32'h7FFFFFFF, 32'h1, 4'b0010, 32'h80000000, 4'b0011};
    v[1]  = '{itype(6'h09, 16'hFFFF), 32'h5, 32'hDEAD, 32'h5, 32'hFFFFFFFF, 4'b0000, 32'h4, 4'b0100};
    v[2]  = '{rtype(4, 6'h03), 32'h123, 32'h80000000, 32'h4, 32'h80000000, 4'b1100, 32'hF8000000, 4'b0010};
    v[3]  = '{rtype(0, 6'h20), 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFF, 32'h1, 4'b0010, 32'h0, 4'b1000};
    v[4]  = '{rtype(0, 6'h21), 32'h7FFFFFFF, 32'h1, 32'h7FFFFFFF, 32'h1, 4'b0000, 32'h80000000, 4'b0010};
    v[5]  = '{rtype(0, 6'h23), 32'h1, 32'h2, 32'h1, 32'h2, 4'b0001, 32'hFFFFFFFF, 4'b0110};
    v[6]  = '{rtype(0, 6'h22), 32'h80000000, 32'h1, 32'h80000000, 32'h1, 4'b0011, 32'h7FFFFFFF, 4'b0001};
    v[7]  = '{rtype(0, 6'h24), 32'hF0F0F0F0, 32'hFF00FF00, 32'hF0F0F0F0, 32'hFF00FF00, 4'b0100, 32'hF000F000, 4'b0010};
    v[8]  = '{rtype(0, 6'h27), 32'h0, 32'h0, 32'h0, 32'h0, 4'b0111, 32'hFFFFFFFF, 4'b0010};
    v[9]  = '{itype(6'h0D, 16'h8001), 32'h10000, 32'h0, 32'h10000, 32'h8001, 4'b0101, 32'h18001, 4'b0000};
    v[10] = '{itype(6'h0A, 16'hFFFF), 32'hFFFFFFFE, 32'h0, 32'hFFFFFFFE, 32'hFFFFFFFF, 4'b1011, 32'h1, 4'b0000};
    v[11] = '{rtype(0, 6'h2B), 32'h1, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFF, 4'b1010, 32'h1, 4'b0100};
    v[12] = '{itype(6'h0F, 16'h1234), 32'h0, 32'h0, 32'h0, 32'h1234, 4'b1000, 32'h12340000, 4'b0000};
    v[13] = '{rtype(1, 6'h00), 32'h0, 32'h80000001, 32'h1, 32'h80000001, 4'b1110, 32'h2, 4'b0100};
    v[14] = '{rtype(0, 6'h06), 32'h24, 32'h1F, 32'h24, 32'h1F, 4'b1101, 32'h1, 4'b0100};
    v[15] = '{itype(6'h0E, 16'hFFFF), 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'hFFFF, 4'b0110, 32'hFFFF0000, 4'b0010};
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      send(v[k].i, v[k].rs, v[k].rt);
      n_cmp++;
      if ({out_valid, in_ready, alu_a, alu_b, alu_aluc} !== {2'b00, v[k].a, v[k].b, v[k].op}) begin
        n_fail++;
        $display("FAIL exec[%0d]: got v=%b rdy=%b a=%h b=%h op=%b want v=0 rdy=0 a=%h b=%h op=%b",
                 k, out_valid, in_ready, alu_a, alu_b, alu_aluc, v[k].a, v[k].b, v[k].op);
      end
      @(posedge clk); #1;
      n_cmp++;
      if ({out_valid, out_illegal, out_r, out_flags} !== {2'b10, v[k].r, v[k].f}) begin
        n_fail++;
        $display("FAIL done[%0d]: got v=%b ill=%b r=%h f=%b want v=1 ill=0 r=%h f=%b",
                 k, out_valid, out_illegal, out_r, out_flags, v[k].r, v[k].f);
      end
      @(posedge clk); #1;
      n_cmp++;
      if ({in_ready, out_valid} !== 2'b10) begin
        n_fail++;
        $display("FAIL idle[%0d]: got rdy=%b v=%b want rdy=1 v=0", k, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_illegal;
    logic [31:0] ill[2];
    ill[0] = itype(6'h3F, 16'h1234);
    ill[1] = rtype(0, 6'h08);
    send(itype(6'h0D, 16'h00F0), 32'hF00, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      send(ill[k], 32'h1111, 32'h2222);
      n_cmp++;
      if ({out_valid, out_illegal, out_r, out_flags, in_ready} !== {2'b11, 32'h0, 4'h0, 1'b0}) begin
        n_fail++;
        $display("FAIL illegal_out[%0d]: got v=%b ill=%b r=%h f=%b rdy=%b want v=1 ill=1 r=0 f=0 rdy=0",
                 k, out_valid, out_illegal, out_r, out_flags, in_ready);
      end
      n_cmp++;
      if ({alu_a, alu_b, alu_aluc} !== {32'hF00, 32'hF0, 4'b0101}) begin
        n_fail++;
        $display("FAIL illegal_alu[%0d]: got a=%h b=%h op=%b want a=00000f00 b=000000f0 op=0101",
                 k, alu_a, alu_b, alu_aluc);
      end
      @(posedge clk); #1;
      n_cmp++;
      if ({in_ready, out_valid} !== 2'b10) begin
        n_fail++;
        $display("FAIL illegal_idle[%0d]: got rdy=%b v=%b want rdy=1 v=0", k, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    send(rtype(0, 6'h21), 32'h1, 32'h2);
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      instr    = itype(6'h0F, 16'hFFFF);
      rs_val   = 32'h7;
      @(posedge clk); #1;
      n_cmp++;
      if ({out_valid, in_ready, out_illegal, out_r, alu_a, alu_aluc} !==
          {3'b100, 32'h3, 32'h1, 4'b0000}) begin
        n_fail++;
        $display("FAIL hold[%0d]: got v=%b rdy=%b ill=%b r=%h a=%h op=%b want v=1 rdy=0 ill=0 r=3 a=1 op=0000",
                 k, out_valid, in_ready, out_illegal, out_r, alu_a, alu_aluc);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL release: got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid);
    end
  endtask

  task automatic test_back_to_back;
    int pulses = 0;
    int bad_r = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    instr     = rtype(0, 6'h21);
    rs_val    = 32'h1;
    rt_val    = 32'h1;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        pulses++;
        if (out_r !== 32'h2) bad_r++;
      end
    end
    in_valid = 1'b0;
    n_cmp++;
    if (pulses !== 3) begin
      n_fail++;
      $display("FAIL b2b_rate: got %0d results in 9 cycles want 3", pulses);
    end
    n_cmp++;
    if (bad_r !== 0) begin
      n_fail++;
      $display("FAIL b2b_data: got %0d wrong results want 0", bad_r);
    end
  endtask

  task automatic test_reset_mid;
    int late = 0;
    // Reset while in EXEC.
    send(rtype(0, 6'h20), 32'h7FFFFFFF, 32'h1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({in_ready, out_valid, out_illegal, out_r, out_flags, alu_a, alu_b, alu_aluc} !==
        {1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0}) begin
      n_fail++;
      $display("FAIL rst_exec: got rdy=%b v=%b ill=%b r=%h f=%b a=%h b=%h op=%b want idle/zeros",
               in_ready, out_valid, out_illegal, out_r, out_flags, alu_a, alu_b, alu_aluc);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (out_valid) late++;
    end
    n_cmp++;
    if (late !== 0) begin
      n_fail++;
      $display("FAIL rst_exec_after: got %0d valid cycles want 0", late);
    end
    // Reset while holding a result in DONE.
    out_ready = 1'b0;
    send(rtype(0, 6'h21), 32'h5, 32'h6);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({in_ready, out_valid, out_r} !== {2'b10, 32'h0}) begin
      n_fail++;
      $display("FAIL rst_done: got rdy=%b v=%b r=%h want rdy=1 v=0 r=0", in_ready, out_valid, out_r);
    end
    rst_n = 1'b1;
    late  = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (out_valid) late++;
    end
    n_cmp++;
    if (late !== 0) begin
      n_fail++;
      $display("FAIL rst_done_after: got %0d valid cycles want 0", late);
    end
    out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    @(posedge clk); #1;
    test_alu_ops();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
